// File: rtl/cvxif_instr_pkg.sv
// Shared types for the CV-X-IF custom vector instructions and the blackbox driver.
package cvxif_instr_pkg;

  localparam int unsigned NumCustomInst  = 2;
  localparam int unsigned MaxVlenDefault = 4;

  typedef enum logic [0:0] {
    VADD2          = 1'b0,
    CAG444toRGB888 = 1'b1
  } custom_vec_op_e;

  typedef enum logic [1:0] {
    BB_IDLE  = 2'd0,
    BB_START = 2'd1,
    BB_RUN   = 2'd2,
    BB_RESP  = 2'd3
  } bb_drv_state_e;

endpackage

// File: rtl/blackbox_word_buf.sv
// MaxVlen x 64 word buffer with one pointer: an ap_fifo read source, or (IsSink) a write sink.
module blackbox_word_buf #(
  parameter int unsigned MaxVlen = 4,
  parameter int unsigned LenW    = $clog2(MaxVlen + 1),
  parameter bit          IsSink  = 1'b0
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     load_i,
  input  logic [MaxVlen-1:0][63:0] load_dat_i,
  input  logic [LenW-1:0]          load_len_i,
  input  logic                     active_i,
  input  logic                     step_i,
  input  logic [63:0]              wr_dat_i,
  output logic [63:0]              dout_o,
  output logic                     avail_o,
  output logic [LenW-1:0]          ptr_o,
  output logic                     err_o,
  output logic [MaxVlen-1:0][63:0] words_o
);

  localparam int unsigned IdxW = (MaxVlen > 1) ? $clog2(MaxVlen) : 1;

  logic [MaxVlen-1:0][63:0] words_q;
  logic [LenW-1:0]          ptr_q;
  logic [LenW-1:0]          len_q;
  logic                     err_q;

  // Same compare serves as empty_n for a source and full_n for a sink.
  assign avail_o = active_i && (ptr_q < len_q);
  assign dout_o  = avail_o ? words_q[ptr_q[IdxW-1:0]] : 64'd0;
  assign ptr_o   = ptr_q;
  assign err_o   = err_q || (ptr_q != len_q);
  assign words_o = words_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      words_q <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else if (load_i) begin
      words_q <= load_dat_i;
      ptr_q   <= '0;
      len_q   <= load_len_i;
      err_q   <= 1'b0;
    end else if (active_i && step_i) begin
      if (avail_o) begin
        if (IsSink) words_q[ptr_q[IdxW-1:0]] <= wr_dat_i;
        ptr_q <= ptr_q + LenW'(1);
      end else begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/blackbox_driver.sv
// Issues one custom vector op to the blackbox (ap_ctrl_hs) and serves its ap_fifo ports.
// Define CVXIF_BBOX_PERF_EN to report START..done cycles on rsp_cycles.
module blackbox_driver
  import cvxif_instr_pkg::*;
#(
  parameter int unsigned MaxVlen = MaxVlenDefault,
  parameter int unsigned LenW    = $clog2(MaxVlen + 1)
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  custom_vec_op_e           req_opcode,
  input  logic [MaxVlen-1:0][63:0] req_in1,
  input  logic [MaxVlen-1:0][63:0] req_in2,
  input  logic [LenW-1:0]          req_in1_len,
  input  logic [LenW-1:0]          req_in2_len,
  input  logic [LenW-1:0]          req_out_len,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [MaxVlen-1:0][63:0] rsp_data,
  output logic [LenW-1:0]          rsp_len,
  output logic                     rsp_err,
  output logic [31:0]              rsp_cycles,
  output logic                     bb_fire,
  output custom_vec_op_e           bb_opcode,
  output logic                     bb_ap_start,
  input  logic                     bb_ap_done,
  input  logic                     bb_ap_idle,
  input  logic                     bb_ap_ready,
  output logic [63:0]              bb_in1_dout,
  output logic                     bb_in1_empty_n,
  input  logic                     bb_in1_read,
  output logic [63:0]              bb_in2_dout,
  output logic                     bb_in2_empty_n,
  input  logic                     bb_in2_read,
  input  logic [63:0]              bb_out_r_din,
  output logic                     bb_out_r_full_n,
  input  logic                     bb_out_r_write
);

  bb_drv_state_e  state_q;
  logic           req_ready_q, rsp_valid_q, bb_fire_q, bb_ap_start_q;
  custom_vec_op_e bb_opcode_q;

  logic accept, active;
  assign accept = (state_q == BB_IDLE) && req_valid;
  assign active = (state_q == BB_START) || (state_q == BB_RUN);

  function automatic logic [LenW-1:0] clamp_len(input logic [LenW-1:0] len);
    return (len > LenW'(MaxVlen)) ? LenW'(MaxVlen) : len;
  endfunction

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q       <= BB_IDLE;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      bb_fire_q     <= 1'b0;
      bb_ap_start_q <= 1'b0;
      bb_opcode_q   <= custom_vec_op_e'('0);
    end else begin
      unique case (state_q)
        BB_IDLE: if (accept) begin
          state_q       <= BB_START;
          req_ready_q   <= 1'b0;
          bb_fire_q     <= 1'b1;
          bb_ap_start_q <= 1'b1;
          bb_opcode_q   <= req_opcode;
        end
        BB_START: begin
          bb_fire_q <= 1'b0;
          if (bb_ap_ready) begin
            bb_ap_start_q <= 1'b0;
            if (bb_ap_done) begin
              state_q     <= BB_RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q <= BB_RUN;
            end
          end
        end
        BB_RUN: if (bb_ap_done) begin
          state_q     <= BB_RESP;
          rsp_valid_q <= 1'b1;
        end
        BB_RESP: if (rsp_ready) begin
          state_q     <= BB_IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          bb_opcode_q <= custom_vec_op_e'('0);
        end
        default: state_q <= BB_IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign bb_fire     = bb_fire_q;
  assign bb_ap_start = bb_ap_start_q;
  assign bb_opcode   = bb_opcode_q;

  logic [LenW-1:0]          in1_ptr, in2_ptr;
  logic                     in1_err, in2_err, out_err;
  logic [MaxVlen-1:0][63:0] in1_words, in2_words;
  logic [63:0]              out_dout;

  blackbox_word_buf #(.MaxVlen(MaxVlen), .LenW(LenW), .IsSink(1'b0)) u_in1 (
    .ap_clk, .ap_rst_n, .load_i(accept), .load_dat_i(req_in1),
    .load_len_i(clamp_len(req_in1_len)), .active_i(active), .step_i(bb_in1_read),
    .wr_dat_i(64'd0), .dout_o(bb_in1_dout), .avail_o(bb_in1_empty_n),
    .ptr_o(in1_ptr), .err_o(in1_err), .words_o(in1_words)
  );

  blackbox_word_buf #(.MaxVlen(MaxVlen), .LenW(LenW), .IsSink(1'b0)) u_in2 (
    .ap_clk, .ap_rst_n, .load_i(accept), .load_dat_i(req_in2),
    .load_len_i(clamp_len(req_in2_len)), .active_i(active), .step_i(bb_in2_read),
    .wr_dat_i(64'd0), .dout_o(bb_in2_dout), .avail_o(bb_in2_empty_n),
    .ptr_o(in2_ptr), .err_o(in2_err), .words_o(in2_words)
  );

  // Sink is loaded with zeros so words the kernel never writes read back as 0.
  blackbox_word_buf #(.MaxVlen(MaxVlen), .LenW(LenW), .IsSink(1'b1)) u_out (
    .ap_clk, .ap_rst_n, .load_i(accept), .load_dat_i('0),
    .load_len_i(clamp_len(req_out_len)), .active_i(active), .step_i(bb_out_r_write),
    .wr_dat_i(bb_out_r_din), .dout_o(out_dout), .avail_o(bb_out_r_full_n),
    .ptr_o(rsp_len), .err_o(out_err), .words_o(rsp_data)
  );

  assign rsp_err = (state_q == BB_RESP) && (in1_err || in2_err || out_err);

  logic unused_sig;
  assign unused_sig = ^{bb_ap_idle, in1_ptr, in2_ptr, in1_words, in2_words, out_dout};

`ifdef CVXIF_BBOX_PERF_EN
  logic [31:0] cyc_q;
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)                        cyc_q <= '0;
    else if (accept)                      cyc_q <= '0;
    else if (active && (cyc_q != '1))     cyc_q <= cyc_q + 32'd1;
  end
  assign rsp_cycles = cyc_q;
`else
  assign rsp_cycles = '0;
`endif

endmodule

// File: tb/tb_blackbox_driver.sv
// Bench for blackbox_driver: table vectors plus random ops against a behavioural kernel/reference model.
module tb_blackbox_driver;
  import cvxif_instr_pkg::*;

  typedef logic [3:0][63:0] vec_t;
  typedef struct {
    custom_vec_op_e op;
    vec_t in1, in2;
    int len1, len2, leno, nr1, nr2, nw, rdly, hold;
    bit dwr;
    int exp_len;
    bit exp_err;
    vec_t exp_data;
  } rec_t;

  logic ap_clk, ap_rst_n;
  logic req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  custom_vec_op_e req_opcode, bb_opcode;
  vec_t req_in1, req_in2, rsp_data;
  logic [2:0] req_in1_len, req_in2_len, req_out_len, rsp_len;
  logic [31:0] rsp_cycles;
  logic bb_fire, bb_ap_start, bb_ap_done, bb_ap_idle, bb_ap_ready;
  logic [63:0] bb_in1_dout, bb_in2_dout, bb_out_r_din;
  logic bb_in1_empty_n, bb_in1_read, bb_in2_empty_n, bb_in2_read, bb_out_r_full_n, bb_out_r_write;

  blackbox_driver dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_in1(req_in1), .req_in2(req_in2),
    .req_in1_len(req_in1_len), .req_in2_len(req_in2_len), .req_out_len(req_out_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_len(rsp_len),
    .rsp_err(rsp_err), .rsp_cycles(rsp_cycles),
    .bb_fire(bb_fire), .bb_opcode(bb_opcode), .bb_ap_start(bb_ap_start),
    .bb_ap_done(bb_ap_done), .bb_ap_idle(bb_ap_idle), .bb_ap_ready(bb_ap_ready),
    .bb_in1_dout(bb_in1_dout), .bb_in1_empty_n(bb_in1_empty_n), .bb_in1_read(bb_in1_read),
    .bb_in2_dout(bb_in2_dout), .bb_in2_empty_n(bb_in2_empty_n), .bb_in2_read(bb_in2_read),
    .bb_out_r_din(bb_out_r_din), .bb_out_r_full_n(bb_out_r_full_n), .bb_out_r_write(bb_out_r_write)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int fire_cnt = 0;
  always @(negedge ap_clk) if (bb_fire) fire_cnt++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Stand-in kernels: only the word transport matters to the driver.
  function automatic logic [63:0] kern(input custom_vec_op_e op, input logic [63:0] a, input logic [63:0] b);
    return (op == VADD2) ? a + b : a ^ (b << 1);
  endfunction

  function automatic vec_t v4(input longint w0, input longint w1, input longint w2, input longint w3);
    vec_t v;
    v[0] = 64'(w0); v[1] = 64'(w1); v[2] = 64'(w2); v[3] = 64'(w3);
    return v;
  endfunction

  // Reference: kernel step k reads word min(k,nr) of each operand (0 past the length),
  // and writes beyond the clamped out length are dropped.
  function automatic rec_t model(input rec_t r);
    rec_t m;
    int c1, c2, co, p1, p2;
    logic [63:0] a, b;
    m  = r;
    c1 = imin(r.len1, 4); c2 = imin(r.len2, 4); co = imin(r.leno, 4);
    m.exp_len  = imin(r.nw, co);
    m.exp_err  = (r.nr1 != c1) || (r.nr2 != c2) || (r.nw != co);
    m.exp_data = '0;
    for (int k = 0; k < m.exp_len; k++) begin
      p1 = imin(k, r.nr1); p2 = imin(k, r.nr2);
      a = (p1 < c1) ? r.in1[p1] : 64'd0;
      b = (p2 < c2) ? r.in2[p2] : 64'd0;
      m.exp_data[k] = kern(r.op, a, b);
    end
    return m;
  endfunction

  function automatic rec_t mk(input custom_vec_op_e op, input vec_t i1, input vec_t i2,
                              input int l1, input int l2, input int lo, input int r1, input int r2,
                              input int w, input int rd, input bit dw, input int h,
                              input int el, input bit ee, input vec_t ed);
    rec_t r;
    r.op = op; r.in1 = i1; r.in2 = i2; r.len1 = l1; r.len2 = l2; r.leno = lo;
    r.nr1 = r1; r.nr2 = r2; r.nw = w; r.rdly = rd; r.dwr = dw; r.hold = h;
    r.exp_len = el; r.exp_err = ee; r.exp_data = ed;
    return r;
  endfunction

  task automatic run_op(input rec_t r);
    int c1, c2, co, s, fires0, p1, p2, pw, waitc, exp_cyc;
    c1 = imin(r.len1, 4); c2 = imin(r.len2, 4); co = imin(r.leno, 4);
    s  = imin(4, 0); s = (r.nr1 > r.nr2) ? r.nr1 : r.nr2; s = (r.nw > s) ? r.nw : s;
    if (s < 1) s = 1;
    chk("req_ready_idle", 256'(req_ready), 256'(1));
    fires0 = fire_cnt;
    req_valid = 1'b1; req_opcode = r.op; req_in1 = r.in1; req_in2 = r.in2;
    req_in1_len = 3'(r.len1); req_in2_len = 3'(r.len2); req_out_len = 3'(r.leno);
    @(negedge ap_clk);
    req_valid = 1'b0;
    chk("fire_first_start", 256'(bb_fire), 256'(1));
    chk("ap_start_high", 256'(bb_ap_start), 256'(1));
    chk("opcode_start", 256'(bb_opcode), 256'(r.op));
    chk("req_ready_busy", 256'(req_ready), 256'(0));
    repeat (r.rdly) @(negedge ap_clk);
    bb_ap_ready = 1'b1; bb_ap_done = r.dwr;
    @(negedge ap_clk);
    bb_ap_ready = 1'b0; bb_ap_done = 1'b0;
    chk("ap_start_drop", 256'(bb_ap_start), 256'(0));
    if (!r.dwr) begin
      for (int k = 0; k < s; k++) begin
        p1 = imin(imin(k, r.nr1), c1); p2 = imin(imin(k, r.nr2), c2); pw = imin(imin(k, r.nw), co);
        chk("in1_empty_n", 256'(bb_in1_empty_n), 256'(p1 < c1));
        chk("in2_empty_n", 256'(bb_in2_empty_n), 256'(p2 < c2));
        chk("out_full_n", 256'(bb_out_r_full_n), 256'(pw < co));
        bb_in1_read = (k < r.nr1); bb_in2_read = (k < r.nr2); bb_out_r_write = (k < r.nw);
        bb_out_r_din = kern(r.op, bb_in1_dout, bb_in2_dout);
        bb_ap_done = (k == s - 1);
        @(negedge ap_clk);
        bb_in1_read = 1'b0; bb_in2_read = 1'b0; bb_out_r_write = 1'b0; bb_ap_done = 1'b0;
      end
    end
    waitc = 0;
    while (!rsp_valid && waitc < 8) begin @(negedge ap_clk); waitc++; end
    chk("rsp_valid_after_done", 256'(rsp_valid), 256'(1));
    for (int h = 0; h < r.hold; h++) begin
      chk("hold_rsp_valid", 256'(rsp_valid), 256'(1));
      chk("hold_rsp_data", 256'(rsp_data), 256'(r.exp_data));
      chk("hold_req_ready", 256'(req_ready), 256'(0));
      @(negedge ap_clk);
    end
`ifdef CVXIF_BBOX_PERF_EN
    exp_cyc = r.rdly + 1 + (r.dwr ? 0 : s);
`else
    exp_cyc = 0;
`endif
    chk("rsp_data", 256'(rsp_data), 256'(r.exp_data));
    chk("rsp_len", 256'(rsp_len), 256'(r.exp_len));
    chk("rsp_err", 256'(rsp_err), 256'(r.exp_err));
    chk("rsp_cycles", 256'(rsp_cycles), 256'(exp_cyc));
    chk("fire_count", 256'(fire_cnt - fires0), 256'(1));
    rsp_ready = 1'b1;
    @(negedge ap_clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_cleared", 256'(rsp_valid), 256'(0));
    chk("req_ready_back", 256'(req_ready), 256'(1));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req_ready"}, 256'(req_ready), 256'(1));
    chk({tag, "_rsp_valid"}, 256'(rsp_valid), 256'(0));
    chk({tag, "_ap_start"}, 256'(bb_ap_start), 256'(0));
    chk({tag, "_fire"}, 256'(bb_fire), 256'(0));
    chk({tag, "_fifo_flags"}, 256'({bb_in1_empty_n, bb_in2_empty_n, bb_out_r_full_n}), 256'(0));
    chk({tag, "_rsp_fields"}, 256'({rsp_data, rsp_len, rsp_err}), 256'(0));
    chk({tag, "_cycles"}, 256'(rsp_cycles), 256'(0));
  endtask

  rec_t tbl[7];
  rec_t r;

  initial begin
    ap_rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_opcode = VADD2;
    req_in1 = '0; req_in2 = '0; req_in1_len = '0; req_in2_len = '0; req_out_len = '0;
    bb_ap_done = 1'b0; bb_ap_idle = 1'b1; bb_ap_ready = 1'b0;
    bb_in1_read = 1'b0; bb_in2_read = 1'b0; bb_out_r_write = 1'b0; bb_out_r_din = '0;
    repeat (2) @(negedge ap_clk);
    chk_quiet("reset");
    ap_rst_n = 1'b1;
    @(negedge ap_clk);

    tbl[0] = mk(VADD2, v4(1, 2, 0, 0), v4(10, 20, 0, 0), 2, 2, 2, 2, 2, 2, 0, 0, 0, 2, 0, v4(11, 22, 0, 0));
    tbl[1] = mk(VADD2, v4(1, 2, 0, 0), v4(10, 20, 0, 0), 2, 2, 2, 2, 2, 2, 1, 0, 5, 2, 0, v4(11, 22, 0, 0));
    tbl[2] = mk(CAG444toRGB888, v4(5, 6, 7, 8), v4(1, 1, 1, 1), 4, 4, 4, 4, 4, 4, 2, 0, 0, 4, 0, v4(7, 4, 5, 10));
    tbl[3] = mk(VADD2, v4(1, 2, 3, 0), v4(10, 20, 30, 0), 3, 3, 3, 3, 3, 4, 0, 0, 1, 3, 1, v4(11, 22, 33, 0));
    tbl[4] = mk(VADD2, v4(0, 0, 0, 0), v4(0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, v4(0, 0, 0, 0));
    tbl[5] = mk(VADD2, v4(1, 2, 3, 4), v4(0, 0, 0, 0), 7, 7, 7, 4, 4, 4, 0, 0, 0, 4, 0, v4(1, 2, 3, 4));
    tbl[6] = mk(CAG444toRGB888, v4(9, 0, 0, 0), v4(9, 0, 0, 0), 1, 1, 0, 1, 1, 1, 1, 0, 0, 0, 1, v4(0, 0, 0, 0));
    for (int i = 0; i < 7; i++) run_op(tbl[i]);

    // Reset in RUN after one word pair consumed: no response, next op unaffected.
    r = tbl[0];
    req_valid = 1'b1; req_opcode = r.op; req_in1 = r.in1; req_in2 = r.in2;
    req_in1_len = 3'd2; req_in2_len = 3'd2; req_out_len = 3'd2;
    @(negedge ap_clk);
    req_valid = 1'b0; bb_ap_ready = 1'b1;
    @(negedge ap_clk);
    bb_ap_ready = 1'b0; bb_in1_read = 1'b1; bb_in2_read = 1'b1;
    @(negedge ap_clk);
    bb_in1_read = 1'b0; bb_in2_read = 1'b0;
    ap_rst_n = 1'b0;
    #1;
    chk_quiet("midrst");
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("midrst_no_rsp", 256'(rsp_valid), 256'(0));
    run_op(tbl[0]);

    for (int i = 0; i < 30; i++) begin
      r.op = custom_vec_op_e'($urandom_range(0, 1));
      for (int w = 0; w < 4; w++) begin
        r.in1[w] = {$urandom, $urandom};
        r.in2[w] = {$urandom, $urandom};
      end
      r.len1 = $urandom_range(0, 6); r.len2 = $urandom_range(0, 6); r.leno = $urandom_range(0, 6);
      r.nr1 = $urandom_range(0, 1) ? imin(r.len1, 4) : $urandom_range(0, 5);
      r.nr2 = $urandom_range(0, 1) ? imin(r.len2, 4) : $urandom_range(0, 5);
      r.nw  = $urandom_range(0, 1) ? imin(r.leno, 4) : $urandom_range(0, 5);
      r.rdly = $urandom_range(0, 2); r.hold = $urandom_range(0, 2);
      r.dwr = (r.nr1 == 0 && r.nr2 == 0 && r.nw == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      r = model(r);
      run_op(r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
